// File: rtl/nnet_result_framer.sv
//============================================================================
// nnet_result_framer : frames an untagged HLS result stream into CHDR packets
// Revision: 1.0
//============================================================================
`default_nettype none

module nnet_result_framer #(
   parameter int          SR_USER_SPP = 131,
   parameter logic [15:0] SPP_DEFAULT = 16'd0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear,
   input  logic         set_stb,
   input  logic [7:0]   set_addr,
   input  logic [31:0]  set_data,
   input  logic [15:0]  src_sid,
   input  logic [15:0]  next_dst_sid,
   input  logic [15:0]  vec_len,
   output logic [15:0]  spp_out,
   input  logic [31:0]  i_tdata,
   input  logic         i_tvalid,
   output logic         i_tready,
   output logic [31:0]  o_tdata,
   output logic         o_tlast,
   output logic         o_tvalid,
   input  logic         o_tready,
   output logic [127:0] o_tuser
);

   localparam logic [7:0] C_SPP_ADDR = SR_USER_SPP[7:0];

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_PKT  = 1'b1
   } state_t;

   state_t         r_state;
   state_t         w_state_nxt;

   logic [15:0]    r_spp;
   logic [11:0]    r_seq;
   logic [15:0]    r_pcnt;
   logic [15:0]    r_plen;
   logic [15:0]    r_vrem;

   logic [31:0]    r_otdata;
   logic           r_otlast;
   logic           r_otvalid;
   logic [127:0]   r_otuser;

   logic [15:0]    w_vrem_cur;
   logic [15:0]    w_vrem_nxt;
   logic           w_pstart;
   logic [15:0]    w_spp_eff;
   logic [15:0]    w_plen_cur;
   logic [15:0]    w_pcnt_cur;
   logic           w_last;
   logic [15:0]    w_len_bytes;
   logic [63:0]    w_hdr;
   logic           w_ready;
   logic           w_acc;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // In IDLE the vector length is taken straight from vec_len so the first
   // sample of a vector can be accepted on the same cycle it is sampled.
   always_comb begin
      w_state_nxt = r_state;
      w_vrem_cur  = (r_state == S_IDLE) ? vec_len : r_vrem;
      w_vrem_nxt  = w_vrem_cur - 16'd1;
      w_pstart    = (r_state == S_IDLE) || (r_pcnt == 16'd0);
      w_spp_eff   = ((r_spp == 16'd0) || (r_spp > w_vrem_cur)) ? w_vrem_cur : r_spp;
      w_plen_cur  = w_pstart ? w_spp_eff : r_plen;
      w_pcnt_cur  = w_pstart ? 16'd0 : r_pcnt;
      w_last      = (w_pcnt_cur == (w_plen_cur - 16'd1));
      w_len_bytes = (w_spp_eff << 2) + 16'd8;
      w_hdr       = {2'b00, 1'b0, (w_spp_eff == w_vrem_cur), r_seq,
                     w_len_bytes, src_sid, next_dst_sid};
      w_ready     = (~r_otvalid | o_tready) & ~clear & ~reset &
                    ~((r_state == S_IDLE) && (vec_len == 16'd0));
      w_acc       = i_tvalid & w_ready;

      if (clear) begin
         w_state_nxt = S_IDLE;
      end else if (w_acc) begin
         if (w_last && (w_vrem_nxt == 16'd0)) begin
            w_state_nxt = S_IDLE;
         end else begin
            w_state_nxt = S_PKT;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_spp     <= SPP_DEFAULT;
         r_seq     <= 12'd0;
         r_pcnt    <= 16'd0;
         r_plen    <= 16'd0;
         r_vrem    <= 16'd0;
         r_otdata  <= 32'd0;
         r_otlast  <= 1'b0;
         r_otvalid <= 1'b0;
         r_otuser  <= 128'd0;
      end else begin
         if (set_stb && (set_addr == C_SPP_ADDR)) begin
            r_spp <= set_data[15:0];
         end

         // The output register is left alone by clear so a held beat still
         // leaves with the header and tlast it was built with.
         if (w_acc) begin
            r_otdata  <= i_tdata;
            r_otlast  <= w_last;
            r_otvalid <= 1'b1;
            if (w_pstart) begin
               r_otuser <= {w_hdr, 64'd0};
            end
         end else if (o_tready) begin
            r_otvalid <= 1'b0;
         end

         if (clear) begin
            r_seq  <= 12'd0;
            r_pcnt <= 16'd0;
            r_vrem <= 16'd0;
         end else if (w_acc) begin
            r_vrem <= w_vrem_nxt;
            if (w_pstart) begin
               r_plen <= w_spp_eff;
            end
            if (w_last) begin
               r_pcnt <= 16'd0;
               r_seq  <= r_seq + 12'd1;
            end else begin
               r_pcnt <= w_pcnt_cur + 16'd1;
            end
         end
      end
   end

   assign spp_out  = r_spp;
   assign i_tready = w_ready;
   assign o_tdata  = r_otdata;
   assign o_tlast  = r_otlast;
   assign o_tvalid = r_otvalid;
   assign o_tuser  = r_otuser;

endmodule

`default_nettype wire

// File: tb/tb_nnet_result_framer.sv
//============================================================================
// tb_nnet_result_framer : randomized bench with a packet-level reference model
// Revision: 1.0
//============================================================================
`default_nettype none

module tb_nnet_result_framer;

   localparam logic [15:0] SPP_DEF  = 16'd5;
   localparam logic [7:0]  SPP_ADDR = 8'd131;
   localparam logic [15:0] SRC      = 16'hABCD;
   localparam logic [15:0] DST      = 16'h1234;

   logic         clk = 1'b0;
   logic         reset, clear, set_stb;
   logic [7:0]   set_addr;
   logic [31:0]  set_data;
   logic [15:0]  src_sid, next_dst_sid, vec_len, spp_out;
   logic [31:0]  i_tdata, o_tdata;
   logic         i_tvalid, i_tready, o_tlast, o_tvalid, o_tready;
   logic [127:0] o_tuser;

   int total = 0;
   int bad   = 0;

   nnet_result_framer #(.SR_USER_SPP(131), .SPP_DEFAULT(SPP_DEF)) dut (
      .clk(clk), .reset(reset), .clear(clear),
      .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
      .src_sid(src_sid), .next_dst_sid(next_dst_sid), .vec_len(vec_len),
      .spp_out(spp_out),
      .i_tdata(i_tdata), .i_tvalid(i_tvalid), .i_tready(i_tready),
      .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid),
      .o_tready(o_tready), .o_tuser(o_tuser)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%h exp=%h", nm, act, exp);
      end
   endtask

   // Packet-level model: counts down what is left of the packet and vector.
   bit           m_live = 0;
   bit           m_acc  = 0;
   bit           m_invec = 0;
   logic         m_ov = 0, m_ol = 0;
   logic [31:0]  m_od = 0;
   logic [127:0] m_ou = 0;
   int           m_spp = 0, m_seq = 0, m_vrem = 0, m_prem = 0;

   function automatic bit exp_ready();
      return !reset && !clear && (!m_ov || o_tready) && !(!m_invec && vec_len == 16'd0);
   endfunction

   always @(posedge clk) begin
      int size;
      m_acc = 0;
      if (reset) begin
         m_live = 1; m_ov = 0; m_ol = 0; m_od = 0; m_ou = 0;
         m_spp = SPP_DEF; m_seq = 0; m_invec = 0; m_vrem = 0; m_prem = 0;
      end else if (m_live) begin
         m_acc = i_tvalid && exp_ready();
         if (m_acc) begin
            if (!m_invec) begin
               m_vrem  = vec_len;
               m_invec = 1;
            end
            if (m_prem == 0) begin
               size   = (m_spp == 0 || m_spp > m_vrem) ? m_vrem : m_spp;
               m_prem = size;
               m_ou   = {2'b00, 1'b0, (size == m_vrem), 12'(m_seq),
                         16'((size * 4 + 8) % 65536), src_sid, next_dst_sid, 64'd0};
            end
            m_ov = 1; m_od = i_tdata; m_ol = (m_prem == 1);
            m_prem--; m_vrem--;
            if (m_ol) begin
               m_seq = (m_seq + 1) % 4096;
               if (m_vrem == 0) m_invec = 0;
            end
         end else if (o_tready) begin
            m_ov = 0;
         end
         if (clear) begin
            m_seq = 0; m_prem = 0; m_vrem = 0; m_invec = 0;
         end
         if (set_stb && set_addr == SPP_ADDR) m_spp = set_data[15:0];
      end
   end

   always @(negedge clk) begin
      if (m_live) begin
         chk("o_tvalid", o_tvalid, m_ov);
         chk("o_tdata",  o_tdata,  m_od);
         chk("o_tlast",  o_tlast,  m_ol);
         chk("o_tuser",  o_tuser,  m_ou);
         chk("spp_out",  spp_out,  m_spp[15:0]);
         chk("i_tready", i_tready, exp_ready());
      end
   end

   // Packet capture for the hand-computed expectations.
   logic [63:0] cap_hdr[$];
   int          cap_len[$];
   int          cap_cnt  = 0;
   int          beat_cnt = 0;

   always @(negedge clk) begin
      if (!reset && o_tvalid && o_tready) begin
         cap_cnt++;
         beat_cnt++;
         if (o_tlast) begin
            cap_hdr.push_back(o_tuser[127:64]);
            cap_len.push_back(cap_cnt);
            cap_cnt = 0;
         end
      end
   end

   function automatic logic [63:0] hdr_lit(input bit eob, input int seq, input int len);
      return {3'b000, eob, 12'(seq), 16'(len), SRC, DST};
   endfunction

   function automatic logic [63:0] qh(input int i);
      return (cap_hdr.size() > i) ? cap_hdr[i] : 64'hFFFF_FFFF_FFFF_FFFF;
   endfunction

   function automatic int ql(input int i);
      return (cap_len.size() > i) ? cap_len[i] : -1;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic caps_reset();
      cap_hdr.delete();
      cap_len.delete();
      cap_cnt  = 0;
      beat_cnt = 0;
   endtask

   task automatic wr_spp(input logic [15:0] v);
      set_stb  = 1'b1;
      set_addr = SPP_ADDR;
      set_data = {16'hDEAD, v};
      tick();
      set_stb  = 1'b0;
      set_addr = 8'd0;
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   task automatic send(input int n, input int rdy_pct, input int vld_pct);
      int got = 0;
      int cyc = 0;
      while (got < n && cyc < n * 20 + 50) begin
         i_tvalid = ($urandom_range(99) < vld_pct);
         i_tdata  = $urandom;
         o_tready = ($urandom_range(99) < rdy_pct);
         tick();
         if (m_acc) got++;
         cyc++;
      end
      i_tvalid = 1'b0;
      o_tready = 1'b1;
      chk("send_budget", got, n);
   endtask

   task automatic drain();
      i_tvalid = 1'b0;
      o_tready = 1'b1;
      repeat (3) tick();
   endtask

   initial begin
      reset = 1'b1; clear = 1'b0; set_stb = 1'b0; set_addr = 8'd0; set_data = 32'd0;
      src_sid = SRC; next_dst_sid = DST; vec_len = 16'd0;
      i_tdata = 32'd0; i_tvalid = 1'b0; o_tready = 1'b1;
      repeat (3) tick();
      chk("rst_tvalid", o_tvalid, 1'b0);
      chk("rst_tuser",  o_tuser,  128'd0);
      chk("rst_spp",    spp_out,  SPP_DEF);
      reset = 1'b0;
      tick();

      // One packet per vector.
      wr_spp(16'd0);
      vec_len = 16'd10;
      caps_reset();
      send(20, 100, 100);
      drain();
      chk("t1_npkt", cap_hdr.size(), 2);
      chk("t1_len0", ql(0), 10);
      chk("t1_len1", ql(1), 10);
      chk("t1_hdr0", qh(0), hdr_lit(1, 0, 48));
      chk("t1_hdr1", qh(1), hdr_lit(1, 1, 48));

      // Split vector.
      pulse_clear();
      wr_spp(16'd4);
      caps_reset();
      send(10, 100, 100);
      drain();
      chk("t2_len0", ql(0), 4);
      chk("t2_len1", ql(1), 4);
      chk("t2_len2", ql(2), 2);
      chk("t2_hdr0", qh(0), hdr_lit(0, 0, 24));
      chk("t2_hdr1", qh(1), hdr_lit(0, 1, 24));
      chk("t2_hdr2", qh(2), hdr_lit(1, 2, 16));

      // Backpressure.
      wr_spp(16'd8);
      vec_len = 16'd16;
      caps_reset();
      send(100, 70, 80);
      drain();
      chk("t3_beats", beat_cnt, 100);
      chk("t3_npkt", cap_hdr.size(), 12);

      // Seqnum wrap.
      pulse_clear();
      wr_spp(16'd0);
      vec_len = 16'd1;
      caps_reset();
      send(4097, 100, 100);
      drain();
      chk("t4_npkt", cap_hdr.size(), 4097);
      chk("t4_hdr4095", qh(4095), hdr_lit(1, 4095, 12));
      chk("t4_hdr4096", qh(4096), hdr_lit(1, 0, 12));

      // Clear mid-vector.
      vec_len = 16'd8;
      wr_spp(16'd8);
      send(3, 100, 100);
      drain();
      pulse_clear();
      caps_reset();
      send(8, 100, 100);
      drain();
      chk("t4c_len", ql(0), 8);
      chk("t4c_hdr", qh(0), hdr_lit(1, 0, 40));

      // Zero length, then SPP change mid-packet.
      pulse_clear();
      wr_spp(16'd4);
      vec_len  = 16'd0;
      i_tvalid = 1'b1;
      for (int k = 0; k < 10; k++) begin
         tick();
         chk("t5_zero_ready", i_tready, 1'b0);
      end
      i_tvalid = 1'b0;
      vec_len  = 16'd6;
      caps_reset();
      send(2, 100, 100);
      wr_spp(16'd2);
      send(4, 100, 100);
      drain();
      chk("t5_len0", ql(0), 4);
      chk("t5_len1", ql(1), 2);
      chk("t5_hdr0", qh(0), hdr_lit(0, 0, 24));
      chk("t5_hdr1", qh(1), hdr_lit(1, 1, 16));
      chk("t5_spp",  spp_out, 16'd2);

      // Reset mid-packet.
      vec_len = 16'd4;
      wr_spp(16'd0);
      send(2, 100, 100);
      reset = 1'b1;
      tick();
      chk("t6_tvalid", o_tvalid, 1'b0);
      chk("t6_spp",    spp_out,  SPP_DEF);
      reset = 1'b0;
      caps_reset();
      send(4, 100, 100);
      drain();
      chk("t6_len", ql(0), 4);
      chk("t6_hdr", qh(0), hdr_lit(1, 0, 24));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
